rc4_prga_decrypt: RTL

Decrypt stage of the RC4 pipeline. It consumes the key-scheduled S array left in `s_memory` by the shuffle FSM, runs the RC4 pseudo-random generation algorithm, and XORs each keystream byte with the encrypted-message ROM. Plaintext goes to the decrypted-message RAM. It attaches to the `*_decrypt` client port of the memory router and uses the same start/finish and memory-request handshake as the init and shuffle FSMs.

---
 rtl/rc4_pkg.sv | 26 ++
 rtl/rc4_prga_decrypt_if.sv | 36 +++
 rtl/rc4_char_check.sv | 12 +
 rtl/rc4_prga_decrypt.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg - shared types and constants for the RC4 decrypt stage.
//   state_e     : PRGA FSM state encoding
//   MSG_LEN_DEF : default message length in bytes
//   CHAR_*      : accepted plaintext range (lower-case letters and space)
package rc4_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_SI,
        S_WAIT_SI,
        S_RD_SJ,
        S_WAIT_SJ,
        S_WR_SI,
        S_WR_SJ,
        S_RD_F,
        S_WAIT_F,
        S_WR_DEC,
        S_DONE
    } state_e;

    localparam int         MSG_LEN_DEF = 32;
    localparam logic [7:0] CHAR_LO     = 8'h61;
    localparam logic [7:0] CHAR_HI     = 8'h7A;
    localparam logic [7:0] CHAR_SP     = 8'h20;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// rc4_prga_decrypt_if - router client port of the decrypt stage.
//   state_start/finish/fail : run handshake
//   decrypt_mem_handler     : router ownership request
//   address/data/wen/q_data : S memory port (registered-address read)
//   rom_address/rom_q       : encrypted message ROM
//   dec_address/dec_data/dec_wen : decrypted message RAM
// master = decrypt FSM, slave = router/memories.
interface rc4_prga_decrypt_if #(
    parameter int MSG_AW = 5
);
    logic              state_start;
    logic              finish;
    logic              fail;
    logic              decrypt_mem_handler;
    logic [7:0]        address;
    logic [7:0]        data;
    logic              wen;
    logic [7:0]        q_data;
    logic [MSG_AW-1:0] rom_address;
    logic [7:0]        rom_q;
    logic [MSG_AW-1:0] dec_address;
    logic [7:0]        dec_data;
    logic              dec_wen;

    modport master (
        input  state_start, q_data, rom_q,
        output finish, fail, decrypt_mem_handler, address, data, wen,
               rom_address, dec_address, dec_data, dec_wen
    );

    modport slave (
        output state_start, q_data, rom_q,
        input  finish, fail, decrypt_mem_handler, address, data, wen,
               rom_address, dec_address, dec_data, dec_wen
    );
endinterface

// File: rtl/rc4_char_check.sv
// rc4_char_check - combinational plaintext filter.
//   byte_i  : candidate plaintext byte
//   valid_o : 1 for 'a'..'z' or space
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       valid_o
);
    assign valid_o = ((byte_i >= CHAR_LO) && (byte_i <= CHAR_HI)) ||
                     (byte_i == CHAR_SP);
endmodule

// File: rtl/rc4_prga_decrypt.sv
// rc4_prga_decrypt - RC4 PRGA + XOR decrypt stage.
// Walks the key-scheduled S array, produces one keystream byte per 9
// cycles, XORs it with the encrypted ROM and writes plaintext to RAM.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : rc4_prga_decrypt_if master (handshake + memory ports)
// Optional feature macro PRGA_VALID_CHECK_EN: abort with fail=1 on the
// first plaintext byte outside 'a'..'z'/space (that byte is still written).
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEF,
    parameter int MSG_AW  = 5
) (
    input  logic clk,
    input  logic reset_n,
    rc4_prga_decrypt_if.master bus
);
    localparam logic [MSG_AW:0] K_LAST = (MSG_AW+1)'(MSG_LEN - 1);

    state_e          state_q, state_d;
    logic [7:0]      i_q, i_d, j_q, j_d;
    logic [7:0]      si_q, si_d, sj_q, sj_d;
    logic [7:0]      f_q, f_d, m_q, m_d;     // keystream byte, ROM byte
    logic [MSG_AW:0] k_q, k_d;
    logic [7:0]      pt;

    assign pt = f_q ^ m_q;

`ifdef PRGA_VALID_CHECK_EN
    logic fail_q, fail_d, pt_ok;

    rc4_char_check u_chk (.byte_i(pt), .valid_o(pt_ok));

    always_ff @(posedge clk) begin
        if (!reset_n) fail_q <= 1'b0;
        else          fail_q <= fail_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            m_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            m_q     <= m_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        m_d     = m_q;
        k_d     = k_q;
`ifdef PRGA_VALID_CHECK_EN
        fail_d  = fail_q;
`endif
        bus.finish              = 1'b0;
        bus.fail                = 1'b0;
        bus.decrypt_mem_handler = (state_q != S_IDLE);
        bus.address             = '0;
        bus.data                = '0;
        bus.wen                 = 1'b0;
        bus.rom_address         = '0;
        bus.dec_address         = '0;
        bus.dec_data            = '0;
        bus.dec_wen             = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.state_start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
`ifdef PRGA_VALID_CHECK_EN
                    fail_d  = 1'b0;
`endif
                    state_d = S_RD_SI;
                end
            end
            S_RD_SI: begin
                bus.address = i_q + 8'd1;
                i_d         = i_q + 8'd1;
                state_d     = S_WAIT_SI;
            end
            S_WAIT_SI: begin
                si_d    = bus.q_data;
                state_d = S_RD_SJ;
            end
            S_RD_SJ: begin
                bus.address = j_q + si_q;
                j_d         = j_q + si_q;
                state_d     = S_WAIT_SJ;
            end
            S_WAIT_SJ: begin
                sj_d    = bus.q_data;
                state_d = S_WR_SI;
            end
            // Swap; when i==j both writes carry the same value, so no
            // ordering hazard exists.
            S_WR_SI: begin
                bus.address = i_q;
                bus.data    = sj_q;
                bus.wen     = 1'b1;
                state_d     = S_WR_SJ;
            end
            S_WR_SJ: begin
                bus.address = j_q;
                bus.data    = si_q;
                bus.wen     = 1'b1;
                state_d     = S_RD_F;
            end
            S_RD_F: begin
                bus.address     = si_q + sj_q;
                bus.rom_address = k_q[MSG_AW-1:0];
                state_d         = S_WAIT_F;
            end
            S_WAIT_F: begin
                f_d     = bus.q_data;
                m_d     = bus.rom_q;
                state_d = S_WR_DEC;
            end
            S_WR_DEC: begin
                bus.dec_address = k_q[MSG_AW-1:0];
                bus.dec_data    = pt;
                bus.dec_wen     = 1'b1;
                k_d             = k_q + 1'b1;
                state_d         = (k_q == K_LAST) ? S_DONE : S_RD_SI;
`ifdef PRGA_VALID_CHECK_EN
                if (!pt_ok) begin
                    fail_d  = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                bus.finish = 1'b1;
`ifdef PRGA_VALID_CHECK_EN
                bus.fail   = fail_q;
`endif
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
